pulse_safety_monitor: RTL and testbench

//   Multi-channel successor to the single-channel laser pulse width/rate checker.
//   Per channel: synchronise the laser pulse, measure high width and rising-to-rising period,

---
 rtl/pulse_safety_monitor_if.sv | 34 +++
 rtl/pulse_safety_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_pulse_safety_monitor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_safety_monitor_if.sv
// rtl/pulse_safety_monitor_if.sv - control, limit and status bundle for pulse_safety_monitor
interface pulse_safety_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
);
  logic [NUM_CH-1:0]       enable;
  logic                    clear_fail;
  logic [NUM_CH-1:0]       laser_pulse;
  logic [NUM_CH*CNT_W-1:0] width_lo_limit;
  logic [NUM_CH*CNT_W-1:0] width_hi_limit;
  logic [NUM_CH*CNT_W-1:0] period_lo_limit;
  logic [NUM_CH*CNT_W-1:0] period_hi_limit;
  logic [NUM_CH-1:0]       width_lo_fail;
  logic [NUM_CH-1:0]       width_hi_fail;
  logic [NUM_CH-1:0]       period_lo_fail;
  logic [NUM_CH-1:0]       period_hi_fail;
  logic                    laser_inhibit;

  // Trigger path / register side: drives pulses and limits, reads status.
  modport master (
    output enable, clear_fail, laser_pulse,
    output width_lo_limit, width_hi_limit, period_lo_limit, period_hi_limit,
    input  width_lo_fail, width_hi_fail, period_lo_fail, period_hi_fail,
    input  laser_inhibit
  );

  // Monitor side.
  modport slave (
    input  enable, clear_fail, laser_pulse,
    input  width_lo_limit, width_hi_limit, period_lo_limit, period_hi_limit,
    output width_lo_fail, width_hi_fail, period_lo_fail, period_hi_fail,
    output laser_inhibit
  );
endinterface

// File: rtl/pulse_safety_monitor.sv
// rtl/pulse_safety_monitor.sv - multi-channel laser pulse width/period safety monitor
module pulse_safety_monitor #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rstn,
  pulse_safety_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  logic [NUM_CH-1:0] wlf_all;
  logic [NUM_CH-1:0] whf_all;
  logic [NUM_CH-1:0] plf_all;
  logic [NUM_CH-1:0] phf_all;
  logic              inhibit_q;
  logic              inhibit_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p_s;
    logic                   p_q;
    logic                   rise;
    logic                   fall;
    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       w_cnt_q;
    logic [CNT_W-1:0]       w_cnt_d;
    logic [CNT_W-1:0]       p_cnt_q;
    logic [CNT_W-1:0]       p_cnt_d;
    logic [CNT_W-1:0]       w_inc;
    logic [CNT_W-1:0]       p_inc;
    logic [CNT_W-1:0]       w_lo;
    logic [CNT_W-1:0]       w_hi;
    logic [CNT_W-1:0]       p_lo;
    logic [CNT_W-1:0]       p_hi;
    logic                   wlf_q;
    logic                   wlf_d;
    logic                   whf_q;
    logic                   whf_d;
    logic                   plf_q;
    logic                   plf_d;
    logic                   phf_q;
    logic                   phf_d;

    // Limits are used live; software only rewrites them while the channel is disabled.
    assign w_lo = bus.width_lo_limit[g*CNT_W +: CNT_W];
    assign w_hi = bus.width_hi_limit[g*CNT_W +: CNT_W];
    assign p_lo = bus.period_lo_limit[g*CNT_W +: CNT_W];
    assign p_hi = bus.period_hi_limit[g*CNT_W +: CNT_W];

    assign p_s  = sync_q[SYNC_STAGES-1];
    assign rise = p_s & ~p_q;
    assign fall = ~p_s & p_q;

    // Saturating increments: a pinned count still reads as larger than any lower limit.
    assign w_inc = (&w_cnt_q) ? w_cnt_q : w_cnt_q + CNT_W'(1);
    assign p_inc = (&p_cnt_q) ? p_cnt_q : p_cnt_q + CNT_W'(1);

    // Bring the asynchronous pulse into the clock domain and keep one cycle of history.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_q <= '0;
        p_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.laser_pulse[g]};
        p_q    <= p_s;
      end
    end

    // Channel state, counters and sticky flags.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= ST_IDLE;
        w_cnt_q <= '0;
        p_cnt_q <= '0;
        wlf_q   <= 1'b0;
        whf_q   <= 1'b0;
        plf_q   <= 1'b0;
        phf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        w_cnt_q <= w_cnt_d;
        p_cnt_q <= p_cnt_d;
        wlf_q   <= wlf_d;
        whf_q   <= whf_d;
        plf_q   <= plf_d;
        phf_q   <= phf_d;
      end
    end

    // Measure width and period, raise flags the cycle a violation is seen.
    always_comb begin
      state_d = state_q;
      w_cnt_d = w_cnt_q;
      p_cnt_d = p_cnt_q;
      wlf_d   = wlf_q;
      whf_d   = whf_q;
      plf_d   = plf_q;
      phf_d   = phf_q;

      case (state_q)
        ST_IDLE: begin
          w_cnt_d = '0;
          p_cnt_d = '0;
          // First pulse after IDLE has no previous rise, so no period check.
          if (bus.enable[g] && rise) begin
            state_d = ST_HIGH;
            w_cnt_d = CNT_W'(1);
            p_cnt_d = CNT_W'(1);
          end
        end

        ST_HIGH: begin
          if (!bus.enable[g]) begin
            state_d = ST_IDLE;
            w_cnt_d = '0;
            p_cnt_d = '0;
          end else if (p_s) begin
            w_cnt_d = w_inc;
            p_cnt_d = p_inc;
            // Overlong pulse is flagged while still high, not at the fall.
            if (w_inc > w_hi) begin
              whf_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end else if (fall) begin
            // w_cnt_q holds the number of high cycles at this point.
            p_cnt_d = p_inc;
            if (w_cnt_q < w_lo) begin
              wlf_d   = 1'b1;
              state_d = ST_FAULT;
            end else begin
              state_d = ST_LOW;
            end
          end
        end

        ST_LOW: begin
          if (!bus.enable[g]) begin
            state_d = ST_IDLE;
            w_cnt_d = '0;
            p_cnt_d = '0;
          end else if (rise) begin
            // p_cnt_q is the rising-to-rising period in cycles.
            if (p_cnt_q < p_lo) begin
              plf_d = 1'b1;
            end
            if (p_cnt_q > p_hi) begin
              phf_d = 1'b1;
            end
            if ((p_cnt_q < p_lo) || (p_cnt_q > p_hi)) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_HIGH;
              w_cnt_d = CNT_W'(1);
              p_cnt_d = CNT_W'(1);
            end
          end else begin
            p_cnt_d = p_inc;
            // Missing pulse: no rise before the period ceiling is exceeded.
            if (p_inc > p_hi) begin
              phf_d   = 1'b1;
              state_d = ST_FAULT;
            end
          end
        end

        ST_FAULT: begin
          // Only clear once the laser is off; a clear during a pulse is ignored.
          if (bus.clear_fail && !p_s) begin
            wlf_d   = 1'b0;
            whf_d   = 1'b0;
            plf_d   = 1'b0;
            phf_d   = 1'b0;
            w_cnt_d = '0;
            p_cnt_d = '0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    assign wlf_all[g] = wlf_q;
    assign whf_all[g] = whf_q;
    assign plf_all[g] = plf_q;
    assign phf_all[g] = phf_q;
  end

  assign inhibit_d = (|wlf_all) | (|whf_all) | (|plf_all) | (|phf_all);

  // Global interlock follows the flag registers one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inhibit_q <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
    end
  end

  assign bus.width_lo_fail  = wlf_all;
  assign bus.width_hi_fail  = whf_all;
  assign bus.period_lo_fail = plf_all;
  assign bus.period_hi_fail = phf_all;
  assign bus.laser_inhibit  = inhibit_q;

endmodule

// File: tb/tb_pulse_safety_monitor.sv
// tb/tb_pulse_safety_monitor.sv - scoreboard bench for pulse_safety_monitor
module tb_pulse_safety_monitor;
  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int VW          = 4 * NUM_CH + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pulse_safety_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  pulse_safety_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output vector: {inhibit, phf[1:0], plf[1:0], whf[1:0], wlf[1:0]}
  logic [VW-1:0] obs_vec;
  assign obs_vec = {bus.laser_inhibit, bus.period_hi_fail, bus.period_lo_fail,
                    bus.width_hi_fail, bus.width_lo_fail};

  typedef struct {
    int            at;
    logic [VW-1:0] vec;
    string         name;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  logic [VW-1:0] exp_vec = '0;
  logic [VW-1:0] prev_vec = '0;
  bit            first_sample = 1'b1;

  task automatic push(input int at, input string nm);
    exp_t t;
    t.at   = at;
    t.vec  = exp_vec;
    t.name = nm;
    exp_q.push_back(t);
  endtask

  // Flag bit rises at 'at', inhibit follows one cycle later.
  task automatic set_flag(input int bitpos, input int at, input string nm);
    exp_vec[bitpos] = 1'b1;
    push(at, nm);
    exp_vec[VW-1] = 1'b1;
    push(at + 1, {nm, "_inhibit"});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input string nm);
    int c;
    c = cyc;
    bus.clear_fail = 1'b1;
    tick(1);
    bus.clear_fail = 1'b0;
    exp_vec[VW-2:0] = '0;
    push(c + 1, nm);
    exp_vec[VW-1] = 1'b0;
    push(c + 2, {nm, "_inhibit"});
  endtask

  task automatic check_drained(input string nm);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d expected events outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL %s_state: outputs %b, required %b", nm, obs_vec, exp_vec);
    end
  endtask

  task automatic set_limits(input int ch, input int wlo, input int whi, input int plo, input int phi);
    bus.width_lo_limit[ch*CNT_W +: CNT_W]  = CNT_W'(wlo);
    bus.width_hi_limit[ch*CNT_W +: CNT_W]  = CNT_W'(whi);
    bus.period_lo_limit[ch*CNT_W +: CNT_W] = CNT_W'(plo);
    bus.period_hi_limit[ch*CNT_W +: CNT_W] = CNT_W'(phi);
  endtask

  // Monitor: every output change is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (first_sample || (obs_vec !== prev_vec)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: outputs %b at cycle %0d, required %b", obs_vec, cyc, prev_vec);
      end else begin
        cur = exp_q.pop_front();
        n_checks++;
        if (obs_vec !== cur.vec) begin
          n_fail++;
          $display("FAIL %s: outputs %b, required %b", cur.name, obs_vec, cur.vec);
        end
        n_checks++;
        if (cyc != cur.at) begin
          n_fail++;
          $display("FAIL %s_cycle: change at cycle %0d, required cycle %0d", cur.name, cyc, cur.at);
        end
      end
    end
    prev_vec     = obs_vec;
    first_sample = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    int f;
    int r;
    bus.enable      = '0;
    bus.clear_fail  = 1'b0;
    bus.laser_pulse = '0;
    for (int ch = 0; ch < NUM_CH; ch++) set_limits(ch, 5, 10, 20, 40);
    exp_vec = '0;
    push(1, "reset_state");
    tick(3);
    rstn = 1'b1;
    bus.enable = 2'b11;
    tick(2);

    // 1: legal pulse train, no flags
    for (int k = 0; k < 5; k++) begin
      bus.laser_pulse[0] = 1'b1;
      tick(7);
      bus.laser_pulse[0] = 1'b0;
      tick(23);
    end
    bus.enable[0] = 1'b0;
    tick(5);
    check_drained("p1_legal_train");

    // 2: short pulse on ch0
    bus.enable[0] = 1'b1;
    tick(2);
    bus.laser_pulse[0] = 1'b1;
    tick(4);
    f = cyc;
    bus.laser_pulse[0] = 1'b0;
    set_flag(0, f + 3, "p2_width_lo_ch0");
    tick(8);
    do_clear("p2_clear");
    tick(3);
    check_drained("p2_done");

    // 3: overlong pulse on ch1, clear while high ignored
    n = cyc;
    bus.laser_pulse[1] = 1'b1;
    set_flag(3, n + 13, "p3_width_hi_ch1");
    tick(20);
    bus.clear_fail = 1'b1;
    tick(1);
    bus.clear_fail = 1'b0;
    tick(29);
    bus.laser_pulse[1] = 1'b0;
    tick(5);
    do_clear("p3_clear");
    tick(3);
    check_drained("p3_done");

    // 4a: pulses 15 cycles apart
    n = cyc;
    bus.laser_pulse[0] = 1'b1;
    tick(7);
    bus.laser_pulse[0] = 1'b0;
    tick(8);
    bus.laser_pulse[0] = 1'b1;
    set_flag(4, n + 18, "p4_period_lo_ch0");
    tick(7);
    bus.laser_pulse[0] = 1'b0;
    tick(5);
    do_clear("p4_clear_lo");
    tick(3);

    // 4b: one pulse then silence -> missing pulse when p_cnt reaches 41
    n = cyc;
    bus.laser_pulse[0] = 1'b1;
    set_flag(6, n + 43, "p4_period_hi_ch0");
    tick(7);
    bus.laser_pulse[0] = 1'b0;
    tick(50);
    do_clear("p4_clear_hi");
    tick(3);
    check_drained("p4_done");

    // 5a: clear on the very cycle a width_lo fault is detected
    bus.laser_pulse[0] = 1'b1;
    tick(4);
    f = cyc;
    bus.laser_pulse[0] = 1'b0;
    set_flag(0, f + 3, "p5_fault_beats_clear");
    tick(2);
    bus.clear_fail = 1'b1;
    tick(1);
    bus.clear_fail = 1'b0;
    tick(5);
    do_clear("p5_clear");
    tick(3);
    check_drained("p5a_done");

    // 5b: all-ones hi limits, 258-cycle pulse: counter must pin at 255, not wrap below width_lo
    bus.enable[1] = 1'b0;
    tick(1);
    set_limits(1, 5, 255, 20, 255);
    bus.enable[1] = 1'b1;
    tick(1);
    bus.laser_pulse[1] = 1'b1;
    tick(258);
    bus.laser_pulse[1] = 1'b0;
    tick(10);
    bus.enable[1] = 1'b0;
    tick(2);
    set_limits(1, 5, 10, 20, 40);
    bus.enable[1] = 1'b1;
    tick(2);
    check_drained("p5b_saturation");

    // 6: fault on ch0, then reset in the middle of a ch1 pulse
    bus.laser_pulse[0] = 1'b1;
    tick(4);
    f = cyc;
    bus.laser_pulse[0] = 1'b0;
    set_flag(0, f + 3, "p6_width_lo_ch0");
    tick(6);
    n = cyc;
    bus.laser_pulse[1] = 1'b1;
    tick(4);
    r = cyc;
    rstn = 1'b0;
    bus.laser_pulse[1] = 1'b0;
    exp_vec = '0;
    push(r, "p6_reset_mid_pulse");
    tick(2);
    rstn = 1'b1;
    tick(4);
    // Rise only 10 cycles after the pre-reset rise: must be treated as a first pulse.
    bus.laser_pulse[1] = 1'b1;
    tick(7);
    bus.laser_pulse[1] = 1'b0;
    tick(20);
    bus.enable[1] = 1'b0;
    tick(5);
    check_drained("p6_first_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
